// File: rtl/router_nch.sv
// router_nch: 1-to-NCH packet router with header address decode, XOR parity check and per-channel FIFOs.
// Define ROUTER_NCH_TIMEOUT_EN to flush any channel whose data sits unread for TIMEOUT cycles.
module router_nch #(
    parameter int unsigned DW      = 8,
    parameter int unsigned NCH     = 3,
    parameter int unsigned AW      = 2,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [DW-1:0]     data_in,
    input  logic [NCH-1:0]    read_enb,
    output logic [NCH*DW-1:0] data_out,
    output logic [NCH-1:0]    valid_out,
    output logic              busy,
    output logic              error
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = DW - AW;
    localparam int unsigned NA = 2 ** AW;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLoad   = 2'd1;
    localparam logic [1:0] StParity = 2'd2;
    localparam logic [1:0] StDrop   = 2'd3;

    localparam logic [LW:0] CntOne = (LW + 1)'(1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] dest_q, dest_d;
    logic [LW:0]   cnt_q, cnt_d;
    logic [DW-1:0] par_q, par_d;
    logic          error_q, error_d;

    logic [AW-1:0]  hdr_addr;
    logic [LW-1:0]  hdr_len;
    logic           hdr_ok;
    logic [NCH-1:0] full;
    logic [NA-1:0]  full_pad;
    logic           wr_en;
    logic [AW-1:0]  wr_sel;

    assign hdr_addr = data_in[AW-1:0];
    assign hdr_len  = data_in[DW-1:AW];
    assign hdr_ok   = 32'(hdr_addr) < NCH;
    // Padding lets an out-of-range header address index safely.
    assign full_pad = NA'(full);
    assign wr_sel   = (state_q == StIdle) ? hdr_addr : dest_q;
    assign error    = error_q;

    always_comb begin
        busy = 1'b0;
        case (state_q)
            StIdle:           busy = hdr_ok && full_pad[hdr_addr];
            StLoad, StParity: busy = full_pad[dest_q];
            default:          busy = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        error_d = error_q;
        wr_en   = 1'b0;
        case (state_q)
            StIdle: begin
                if (pkt_valid && !busy) begin
                    error_d = 1'b0;
                    par_d   = data_in;
                    if (hdr_ok) begin
                        wr_en   = 1'b1;
                        dest_d  = hdr_addr;
                        cnt_d   = {1'b0, hdr_len};
                        state_d = (hdr_len == '0) ? StParity : StLoad;
                    end else begin
                        // Count covers the payload plus the parity byte.
                        cnt_d   = {1'b0, hdr_len} + CntOne;
                        state_d = StDrop;
                    end
                end
            end
            StLoad: begin
                if (!busy) begin
                    wr_en = 1'b1;
                    par_d = par_q ^ data_in;
                    cnt_d = cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (!busy) begin
                    wr_en   = 1'b1;
                    error_d = (data_in != par_q);
                    state_d = StIdle;
                end
            end
            default: begin
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            dest_q  <= '0;
            cnt_q   <= '0;
            par_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            error_q <= error_d;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DW-1:0] mem_q [DEPTH];
        logic [PW-1:0] wptr_q, rptr_q;
        logic [PW:0]   count_q;
        logic [DW-1:0] dout_q;
        logic          wr_c, rd_c, flush_c;

        assign wr_c          = wr_en && (wr_sel == AW'(c));
        assign rd_c          = read_enb[c] && (count_q != '0);
        assign full[c]       = (count_q == (PW + 1)'(DEPTH));
        assign valid_out[c]  = (count_q != '0);
        assign data_out[c*DW +: DW] = dout_q;

`ifdef ROUTER_NCH_TIMEOUT_EN
        localparam int unsigned TW = $clog2(TIMEOUT + 1);
        logic [TW-1:0] tcnt_q;

        assign flush_c = (tcnt_q == TW'(TIMEOUT));

        always_ff @(posedge clock) begin
            if (reset || flush_c || !valid_out[c] || read_enb[c]) begin
                tcnt_q <= '0;
            end else begin
                tcnt_q <= tcnt_q + TW'(1);
            end
        end
`else
        assign flush_c = 1'b0;
`endif

        always_ff @(posedge clock) begin
            if (reset) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
                dout_q  <= '0;
            end else if (flush_c) begin
                // Flush wins over a same-cycle write or read.
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (wr_c) begin
                    wptr_q <= wptr_q + PW'(1);
                end
                if (rd_c) begin
                    dout_q <= mem_q[rptr_q];
                    rptr_q <= rptr_q + PW'(1);
                end
                case ({wr_c, rd_c})
                    2'b10:   count_q <= count_q + (PW + 1)'(1);
                    2'b01:   count_q <= count_q - (PW + 1)'(1);
                    default: count_q <= count_q;
                endcase
            end
        end

        always_ff @(posedge clock) begin
            if (wr_c && !flush_c) begin
                mem_q[wptr_q] <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_router_nch.sv
// tb_router_nch: directed self-checking bench for router_nch (NCH=3, DW=8, AW=2, DEPTH=16).
// Build with ROUTER_NCH_TIMEOUT_EN defined to exercise the channel flush path.
module tb_router_nch;
    localparam int unsigned TIMEOUT = 30;

    logic        clock;
    logic        reset;
    logic        pkt_valid;
    logic [7:0]  data_in;
    logic [2:0]  read_enb;
    logic [23:0] data_out;
    logic [2:0]  valid_out;
    logic        busy;
    logic        error;

    int n_tests;
    int n_fail;
    int st;

    logic [7:0] tx_b[$];
    logic       tx_v[$];
    logic [7:0] exp_q[$];

    router_nch #(
        .DW(8), .NCH(3), .AW(2), .DEPTH(16), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .pkt_valid(pkt_valid),
        .data_in  (data_in),
        .read_enb (read_enb),
        .data_out (data_out),
        .valid_out(valid_out),
        .busy     (busy),
        .error    (error)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clock);
        reset     = 1'b1;
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        read_enb  = 3'b000;
        @(negedge clock);
        reset = 1'b0;
        tx_b.delete();
        tx_v.delete();
        exp_q.delete();
    endtask

    task automatic push_byte(input logic pv, input logic [7:0] b, input bit track);
        tx_v.push_back(pv);
        tx_b.push_back(b);
        if (track) exp_q.push_back(b);
    endtask

    task automatic build_pkt(input logic [7:0] hdr, input logic [7:0] start,
                             input logic [7:0] step, input logic [7:0] par, input bit track);
        logic [7:0] b;
        push_byte(1'b1, hdr, track);
        b = start;
        for (int i = 0; i < int'(hdr[7:2]); i++) begin
            push_byte(1'b1, b, track);
            b = b + step;
        end
        push_byte(1'b0, par, track);
    endtask

    // Presents one byte at a negedge and holds it until busy is low; it is taken at the next posedge.
    task automatic send_byte(input logic pv, input logic [7:0] b, output int stalls);
        stalls = 0;
        @(negedge clock);
        pkt_valid = pv;
        data_in   = b;
        #1;
        while (busy === 1'b1 && stalls < 200) begin
            stalls++;
            @(negedge clock);
            #1;
        end
        if (stalls >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_byte: busy stuck high, byte %h not accepted", b);
        end
    endtask

    task automatic send_n(input int n, output int stalls);
        int s;
        logic pv;
        logic [7:0] b;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            if (tx_b.size() == 0) break;
            pv = tx_v.pop_front();
            b  = tx_b.pop_front();
            send_byte(pv, b, s);
            stalls += s;
        end
    endtask

    task automatic drain(input int c, input int n);
        int got;
        int guard;
        logic pend;
        logic [7:0] want;
        got   = 0;
        guard = 0;
        @(negedge clock);
        read_enb[c] = 1'b1;
        while (got < n && guard < 600) begin
            pend = valid_out[c];
            @(negedge clock);
            guard++;
            if (pend) begin
                if (exp_q.size() != 0) want = exp_q.pop_front();
                else want = 8'h00;
                n_tests++;
                if (data_out[c*8 +: 8] !== want) begin
                    n_fail++;
                    $display("FAIL drain ch%0d byte %0d: got %h want %h",
                             c, got, data_out[c*8 +: 8], want);
                end
                got++;
            end
        end
        read_enb[c] = 1'b0;
        n_tests++;
        if (got != n) begin
            n_fail++;
            $display("FAIL drain ch%0d count: got %0d bytes want %0d", c, got, n);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (data_out !== 24'h0) begin
            n_fail++; $display("FAIL reset data_out: got %h want 000000", data_out);
        end
        n_tests++;
        if (valid_out !== 3'b000) begin
            n_fail++; $display("FAIL reset valid_out: got %b want 000", valid_out);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset busy: got %b want 0", busy);
        end
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++; $display("FAIL reset error: got %b want 0", error);
        end
    endtask

    task automatic test_single_packet();
        apply_reset();
        build_pkt(8'h42, 8'h00, 8'h02, 8'h42, 1'b1);
        send_n(16, st);
        @(negedge clock);
        #1;
        n_tests++;
        if (valid_out !== 3'b100) begin
            n_fail++; $display("FAIL single valid_out: got %b want 100", valid_out);
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL single busy when full: got %b want 1", busy);
        end
        fork
            send_n(2, st);
            drain(2, 18);
        join
        n_tests++;
        if (valid_out !== 3'b000) begin
            n_fail++; $display("FAIL single valid_out after drain: got %b want 000", valid_out);
        end
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++; $display("FAIL single error: got %b want 0", error);
        end
    endtask

    task automatic test_parity();
        apply_reset();
        build_pkt(8'h38, 8'h00, 8'h02, 8'h3A, 1'b1);
        send_n(16, st);
        @(negedge clock);
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++; $display("FAIL parity good error: got %b want 0", error);
        end
        n_tests++;
        if (valid_out !== 3'b001) begin
            n_fail++; $display("FAIL parity valid_out: got %b want 001", valid_out);
        end
        drain(0, 16);
        build_pkt(8'h38, 8'h00, 8'h02, 8'h3B, 1'b1);
        send_n(16, st);
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++; $display("FAIL parity bad error early: got %b want 0", error);
        end
        @(negedge clock);
        n_tests++;
        if (error !== 1'b1) begin
            n_fail++; $display("FAIL parity bad error: got %b want 1", error);
        end
        drain(0, 16);
        n_tests++;
        if (error !== 1'b1) begin
            n_fail++; $display("FAIL parity error hold: got %b want 1", error);
        end
        build_pkt(8'h01, 8'h00, 8'h00, 8'h01, 1'b1);
        send_n(1, st);
        send_n(1, st);
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++; $display("FAIL parity error clear at header: got %b want 0", error);
        end
        @(negedge clock);
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++; $display("FAIL parity len0 error: got %b want 0", error);
        end
        drain(1, 2);
    endtask

    task automatic test_bad_addr();
        apply_reset();
        build_pkt(8'h0B, 8'h11, 8'h11, 8'h00, 1'b0);
        send_n(4, st);
        n_tests++;
        if (st !== 0) begin
            n_fail++; $display("FAIL badaddr busy stalls: got %0d want 0", st);
        end
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++; $display("FAIL badaddr error early: got %b want 0", error);
        end
        @(negedge clock);
        n_tests++;
        if (error !== 1'b1) begin
            n_fail++; $display("FAIL badaddr error: got %b want 1", error);
        end
        n_tests++;
        if (valid_out !== 3'b000) begin
            n_fail++; $display("FAIL badaddr valid_out: got %b want 000", valid_out);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        build_pkt(8'h41, 8'h80, 8'h01, 8'h41, 1'b1);
        build_pkt(8'h41, 8'h90, 8'h01, 8'h41, 1'b1);
        send_n(16, st);
        fork
            send_n(20, st);
            begin
                repeat (3) @(negedge clock);
                #2;
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++; $display("FAIL b2b busy full: got %b want 1", busy);
                end
                n_tests++;
                if (valid_out !== 3'b010) begin
                    n_fail++; $display("FAIL b2b valid_out: got %b want 010", valid_out);
                end
                read_enb[1] = 1'b1;
                @(negedge clock);
                #2;
                read_enb[1] = 1'b0;
                void'(exp_q.pop_front());
                n_tests++;
                if (data_out[15:8] !== 8'h41) begin
                    n_fail++; $display("FAIL b2b first pop: got %h want 41", data_out[15:8]);
                end
                n_tests++;
                if (busy !== 1'b0) begin
                    n_fail++; $display("FAIL b2b busy after read: got %b want 0", busy);
                end
                @(negedge clock);
                #2;
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++; $display("FAIL b2b busy refilled: got %b want 1", busy);
                end
                drain(1, 35);
            end
        join
        n_tests++;
        if (valid_out !== 3'b000) begin
            n_fail++; $display("FAIL b2b valid_out end: got %b want 000", valid_out);
        end
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++; $display("FAIL b2b error: got %b want 0", error);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        build_pkt(8'h2A, 8'h01, 8'h01, 8'h00, 1'b1);
        send_n(5, st);
        @(negedge clock);
        n_tests++;
        if (valid_out !== 3'b100) begin
            n_fail++; $display("FAIL rstmid valid_out before: got %b want 100", valid_out);
        end
        apply_reset();
        n_tests++;
        if (valid_out !== 3'b000) begin
            n_fail++; $display("FAIL rstmid valid_out: got %b want 000", valid_out);
        end
        n_tests++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            n_fail++; $display("FAIL rstmid busy/error: got %b/%b want 0/0", busy, error);
        end
        push_byte(1'b1, 8'h09, 1'b1);
        push_byte(1'b1, 8'hA5, 1'b1);
        push_byte(1'b1, 8'h5A, 1'b1);
        push_byte(1'b0, 8'hF6, 1'b1);
        send_n(4, st);
        @(negedge clock);
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++; $display("FAIL rstmid error: got %b want 0", error);
        end
        n_tests++;
        if (valid_out !== 3'b010) begin
            n_fail++; $display("FAIL rstmid valid_out after: got %b want 010", valid_out);
        end
        drain(1, 4);
    endtask

    task automatic test_timeout();
        apply_reset();
        build_pkt(8'h05, 8'h77, 8'h00, 8'h72, 1'b1);
        fork
            send_n(3, st);
            begin
                int k;
                bit rose;
                rose = 1'b0;
                for (int g = 0; g < 20; g++) begin
                    @(negedge clock);
                    if (valid_out[1] === 1'b1) begin
                        rose = 1'b1;
                        break;
                    end
                end
                n_tests++;
                if (!rose) begin
                    n_fail++; $display("FAIL timeout rise: valid_out[1] got 0 want 1");
                end
                k = 0;
                while (valid_out[1] === 1'b1 && k < int'(TIMEOUT) + 10) begin
                    @(negedge clock);
                    k++;
                end
`ifdef ROUTER_NCH_TIMEOUT_EN
                n_tests++;
                if (k != int'(TIMEOUT) + 1) begin
                    n_fail++; $display("FAIL timeout fall: got %0d cycles want %0d", k, TIMEOUT + 1);
                end
`else
                n_tests++;
                if (valid_out[1] !== 1'b1) begin
                    n_fail++; $display("FAIL timeout hold: valid_out[1] got %b after %0d want 1",
                                       valid_out[1], k);
                end
`endif
            end
        join
    endtask

    initial begin
        clock     = 1'b0;
        reset     = 1'b1;
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        read_enb  = 3'b000;
        n_tests   = 0;
        n_fail    = 0;
        st        = 0;
        test_reset();
        test_single_packet();
        test_parity();
        test_bad_addr();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
